// File: rtl/bin2ascii_stream.sv
// Streams an unsigned sample as DIGITS ASCII decimal bytes (plus optional CR/LF) over valid/ready.
// Conversion is an iterative double-dabble; values that do not fit saturate to all nines.
module bin2ascii_stream #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned LZ_MODE = 0,
    parameter int unsigned TERM    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_value,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] TopIdx = IdxW'(DIGITS - 1);

    typedef enum logic [2:0] {StIdle, StConvert, StEmit, StTermCr, StTermLf} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BcdW-1:0]  bcd_q;
    logic [CntW-1:0]  cnt_q;
    logic [IdxW-1:0]  idx_q;
    logic             sat_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             overflow_q;

    logic [BcdW-1:0]  bcd_adj;
    logic [BcdW-1:0]  bcd_shl;
    logic [WIDTH-1:0] shift_shl;
    logic             carry;
    logic [IdxW-1:0]  idx_dec;
    logic [8:0]       first_byte;
    logic [8:0]       next_byte;

    // Returns {valid, byte} for digit idx; valid=0 marks a suppressed leading zero.
    function automatic logic [8:0] emit_byte(input logic [BcdW-1:0] bcd,
                                             input logic [IdxW-1:0] idx,
                                             input logic sat);
        int unsigned i;
        logic [3:0]  d;
        logic        upper_nz;
        i        = 32'(idx);
        d        = 4'd0;
        upper_nz = 1'b0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (j == i) d = bcd[4*j +: 4];
            if (j >= i && bcd[4*j +: 4] != 4'd0) upper_nz = 1'b1;
        end
        if (sat) return {1'b1, 8'h39};
        if (!upper_nz && i != 0) begin
            if (LZ_MODE == 0) return {1'b1, 8'h30};
            if (LZ_MODE == 1) return {1'b1, 8'h20};
            return {1'b0, 8'h00};
        end
        return {1'b1, 8'h30 + {4'h0, d}};
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
        carry      = bcd_adj[BcdW-1];
        bcd_shl    = {bcd_adj[BcdW-2:0], shift_q[WIDTH-1]};
        shift_shl  = {shift_q[WIDTH-2:0], 1'b0};
        idx_dec    = (idx_q == '0) ? '0 : idx_q - IdxW'(1);
        first_byte = emit_byte(bcd_shl, TopIdx, sat_q | carry);
        next_byte  = emit_byte(bcd_q, idx_dec, sat_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sat_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q    <= in_value;
                        bcd_q      <= '0;
                        sat_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        cnt_q      <= CntW'(WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= StConvert;
                    end
                end
                StConvert: begin
                    shift_q <= shift_shl;
                    bcd_q   <= bcd_shl;
                    sat_q   <= sat_q | carry;
                    cnt_q   <= cnt_q - CntW'(1);
                    // Present the first digit in the same edge that finishes the last shift.
                    if (cnt_q == CntW'(1)) begin
                        state_q    <= StEmit;
                        idx_q      <= TopIdx;
                        overflow_q <= sat_q | carry;
                        tx_valid_q <= first_byte[8];
                        tx_data_q  <= first_byte[7:0];
                    end
                end
                StEmit: begin
                    if (!tx_valid_q || tx_ready) begin
                        if (idx_q == '0) begin
                            if (TERM != 0) begin
                                state_q    <= StTermCr;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= 8'h0D;
                            end else begin
                                state_q    <= StIdle;
                                tx_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                            end
                        end else begin
                            idx_q      <= idx_dec;
                            tx_valid_q <= next_byte[8];
                            tx_data_q  <= next_byte[7:0];
                        end
                    end
                end
                StTermCr: begin
                    if (tx_ready) begin
                        tx_data_q <= 8'h0A;
                        state_q   <= StTermLf;
                    end
                end
                StTermLf: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready = (state_q == StIdle);
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: doc/bin2ascii_stream.md
# bin2ascii_stream

Sequential binary-to-ASCII decimal formatter feeding the UART transmitter. It accepts one unsigned WIDTH-bit sample (for example a detected maximum) over a valid/ready handshake, converts it to DIGITS decimal digits with an iterative shift-add-3 (double-dabble) engine, and streams the ASCII bytes, plus an optional CR/LF terminator, over a byte valid/ready interface. It replaces fixed lookup-table digit conversion with a width- and digit-count-parametrised block that adds overflow saturation, leading-zero handling and backpressure.

## Interface
- WIDTH, 8: input value width in bits, 4..32.
- DIGITS, 3: decimal digits produced, 1..10.
- LZ_MODE, 0: leading-zero handling. 0 = pad with '0' (0x30), 1 = pad with space (0x20), 2 = suppress.
- TERM, 1: 0 = no terminator, 1 = append 0x0D then 0x0A.
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: a sample is offered on in_value.
- in_value, input, WIDTH: unsigned sample.
- in_ready, output, 1: high only in IDLE.
- tx_data, output, 8: ASCII byte to the UART TX.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: the UART TX accepts the byte.
- busy, output, 1: high in any state other than IDLE.
- overflow, output, 1: the current or last frame saturated. Cleared on the next accept.

## Operation
- States are IDLE, CONVERT, EMIT, TERM_CR and TERM_LF.
- **IDLE**
  - in_ready=1.
  - When in_valid is high, capture in_value into the shift register, clear the BCD register (4·DIGITS bits), clear overflow, load cnt=WIDTH, and go to CONVERT.
- **CONVERT** (exactly WIDTH cycles). Each cycle:
  - add 3 to every BCD nibble ≥5;
  - then shift {BCD, shift register} left by one.
  - If the bit shifted out of the top BCD nibble is 1, set the internal sat flag.
  - When cnt reaches 1, go to EMIT with digit index = DIGITS−1 (most significant digit).
- **Saturation.** If sat is set, every emitted digit is '9' (0x39), and overflow=1 from EMIT entry until the next accept. LZ_MODE does not apply to a saturated frame.
- **EMIT.** The current digit d maps to tx_data = 0x30+d.
  - A leading zero is a zero digit with every more-significant digit also zero, and index > 0. The least significant digit is never treated as leading.
  - LZ_MODE 0: a leading zero is emitted as 0x30.
  - LZ_MODE 1: a leading zero is emitted as 0x20.
  - LZ_MODE 2: a leading zero is skipped. It costs one cycle with tx_valid=0, then the index decrements.
  - An emitted byte advances only on tx_valid & tx_ready.
  - After index 0 completes, go to TERM_CR if TERM=1, otherwise IDLE.
- **TERM_CR / TERM_LF.** Emit 0x0D, then 0x0A, under the same handshake. After TERM_LF completes, go to IDLE.
- **Output stability.** While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops without a handshake.
- **Width rules.**
  - The BCD register is 4·DIGITS bits.
  - cnt is $clog2(WIDTH+1) bits.
  - A nibble never exceeds 9 after its adjust step.
- **Reset.** Asserting reset at any time, including mid-CONVERT or mid-EMIT, aborts the frame immediately. The partial frame is not resumed.

## Timing
- Reset values:
  - state=IDLE;
  - in_ready=1;
  - busy=0;
  - tx_valid=0;
  - tx_data=0x00;
  - overflow=0;
  - internal shift, BCD and count registers all zero.
- All outputs except in_ready are registered. in_ready is decoded from the state register.
- Accept in cycle k, the cycle with in_valid & in_ready. Then:
  - busy=1 from k+1;
  - the CONVERT shifts occupy k+1..k+WIDTH;
  - the first tx_valid=1 occurs in cycle k+WIDTH+1 (LZ_MODE 2: plus one cycle per skipped digit).
- **Minimum frame length with tx_ready held high**, from accept to IDLE re-entry, is WIDTH+DIGITS+2·TERM cycles. in_ready rises in the cycle after the last handshake.
- **Back-to-back.** An in_valid held high is accepted in the first IDLE cycle.
- **Simultaneous events.** In_valid during busy is ignored. The upstream must hold in_valid until in_ready.

## Test plan
- **Full-scale value.** WIDTH=8, DIGITS=3, LZ_MODE=0, TERM=1, tx_ready=1, in_value=255 → bytes 0x32, 0x35, 0x35, 0x0D, 0x0A. The first tx_valid comes 9 cycles after accept. overflow=0.
- **Leading-zero modes**, in_value=7:
  - LZ_MODE 0 → 0x30, 0x30, 0x37;
  - LZ_MODE 1 → 0x20, 0x20, 0x37;
  - LZ_MODE 2 → 0x37 only, first tx_valid 11 cycles after accept.
  - in_value=0 with LZ_MODE 2 → single 0x30.
- **Overflow.** DIGITS=2, in_value=200 → 0x39, 0x39, 0x0D, 0x0A and overflow=1. The next accept of 42 clears overflow and emits 0x34, 0x32.
- **Backpressure.** Toggle tx_ready pseudo-randomly over 100 random values → the byte stream matches the decimal string of each value exactly. tx_data is stable whenever tx_valid & !tx_ready.
- **Reset mid-operation.** Assert reset during CONVERT and again during the second EMIT byte → outputs return to their reset values asynchronously. The next frame (123) emits 0x31, 0x32, 0x33 cleanly.
- **Parametric sweep.** WIDTH=16, DIGITS=5, value=65535 → "65535". Also run WIDTH=4, DIGITS=1, value=15 → '9' with overflow=1.
